halt_dump_unit: RTL and testbench
=================================

# halt_dump_unit

Post-halt memory dump engine inside `top`, downstream of the CPU core and data memory. It watches the decode-stage instruction for either halt encoding and freezes the core, waits for the pipeline to drain, then scans the entire data memory through a read port. Every nonzero word goes out, with its address, on a valid/ready stream. This replaces end-of-run memory dumps done from the bench with an in-design, synthesizable path.

## Interface
Parameters:
- `ADDR_W`, 16: data-memory address width; scan covers 0 .. 2**ADDR_W-1.
- `DATA_W`, 16: memory word width.
- `DRAIN_CYCLES`, 10: cycles to wait after halt before the first memory read; range 1..255.
- `HALT_A`, 16'hE000: halt encoding A (`11100_00000000000`).
- `HALT_B`, 16'hE7FF: halt encoding B.

Ports:
- `clk`, in, 1: single clock; all state on posedge.
- `reset`, in, 1: asynchronous, active-low reset (0 = reset asserted).
- `instr`, in, 16: core decode-stage instruction.
- `instr_valid`, in, 1: `instr` holds a real (non-bubble) instruction.
- `halted`, out, 1: halt seen; core must stall all fetch/writeback while 1.
- `mem_rd_en`, out, 1: data-memory read strobe.
- `mem_addr`, out, ADDR_W: read address.
- `mem_rdata`, in, DATA_W: read data, valid exactly 1 cycle after `mem_rd_en`.
- `dump_valid`, out, 1: `dump_data`/`dump_addr` hold a nonzero word.
- `dump_ready`, in, 1: consumer accepts the beat.
- `dump_data`, out, DATA_W: nonzero memory word.
- `dump_addr`, out, ADDR_W: address of `dump_data`.
- `word_count`, out, ADDR_W+1: number of beats accepted so far.
- `done`, out, 1: scan complete.

## Operation
- States:
  - RUN → DRAIN when `instr_valid`=1 and `instr` equals `HALT_A` or `HALT_B`.
  - DRAIN: counts `DRAIN_CYCLES` cycles, then → READ with address 0.
  - READ: `mem_rd_en`=1, `mem_addr`=scan address; → CHECK.
  - CHECK: `mem_rdata` sampled.
    - If nonzero, it is captured into `dump_data`/`dump_addr` and the state → EMIT.
    - If zero and the address is not the last, the address increments and the state → READ.
    - If zero and the address is last, → DONE.
  - EMIT: `dump_valid`=1 until a cycle with `dump_ready`=1. On that edge `word_count` increments, then → READ (next address) or → DONE if the address is last.
  - DONE: terminal; `done`=1 and `halted`=1 until reset.
- Halt match outside RUN is ignored. A halt encoding with `instr_valid`=0 is ignored.
- Scan address register is ADDR_W+1 bits wide internally. It never wraps past 2**ADDR_W-1; the last address terminates the scan.
- `halted` = 1 in every state except RUN.
- While in EMIT, `dump_data` and `dump_addr` stay stable until accepted. `dump_valid` never drops without acceptance.
- `mem_rd_en` is 0 in all states except READ. `mem_addr` holds its last value outside READ.

## Timing
- Reset (`reset`=0, async): state RUN.
  - Outputs: `halted`, `mem_rd_en`, `dump_valid`, `done` = 0.
  - `mem_addr`, `dump_data`, `dump_addr`, `word_count` = 0.
- `halted` rises on the first posedge at which the matching instruction is sampled.
- The first `mem_rd_en` is asserted exactly `DRAIN_CYCLES`+1 cycles after `halted` rises.
- Zero word: 2 cycles (READ, CHECK).
- Nonzero word with `dump_ready` held 1: 3 cycles (READ, CHECK, EMIT). `dump_valid` is asserted the cycle after CHECK.
- `done` rises on the edge that leaves CHECK or EMIT for the last address.
- Reset asserted mid-scan aborts immediately. No partial beat is held. A later halt restarts the scan at address 0 with `word_count`=0.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with random `instr` → all outputs 0 and `halted`=0. Release → still in RUN.
- Basic dump: ADDR_W=4, memory zero except mem[3]=16'h1234 and mem[15]=16'hBEEF, `dump_ready`=1, halt 16'hE000 with valid.
  - Required: first `mem_rd_en` at halt+11 cycles.
  - Beats (3,1234) then (15,BEEF).
  - `done`=1 with `word_count`=2.
- Backpressure: same image, `dump_ready`=0 for 5 cycles during beat (3,1234).
  - Required: `dump_valid`=1 and data/addr unchanged for all 5 cycles.
  - No `mem_rd_en` during the stall.
  - Exactly one count increment on acceptance.
- Halt qualification:
  - 16'hE7FF with `instr_valid`=0 → `halted` stays 0.
  - 16'hE7FF with `instr_valid`=1 → `halted`=1.
  - A second halt issued during DRAIN → no restart of the drain count.
- All-zero memory, ADDR_W=4 → no `dump_valid` ever; `done` at 11+2×16 cycles after halt; `word_count`=0.
- Reset mid-EMIT: all outputs return to 0 asynchronously. A new halt rescans from address 0 and reproduces the full beat sequence.

Source files
------------

// File: rtl/halt_dump_unit.sv
// halt_dump_unit: freezes the core on a halt instruction, drains, then streams every nonzero data-memory word
module halt_dump_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DRAIN_CYCLES = 10,
  parameter logic [15:0] HALT_A = 16'hE000,
  parameter logic [15:0] HALT_B = 16'hE7FF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              halted,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [ADDR_W:0]   word_count,
  output logic              done
);
  typedef enum logic [2:0] {RUN, DRAIN, READ, CHECK, EMIT, DONE} state_t;
  localparam logic [ADDR_W:0] LAST = {1'b0, {ADDR_W{1'b1}}};
  state_t          state;
  logic [7:0]      cnt;
  logic [ADDR_W:0] addr;
  logic [ADDR_W:0] addr_nx;
  logic            last;
  logic            halt_hit;
  assign addr_nx  = addr + (ADDR_W+1)'(1);
  assign last     = addr == LAST;
  assign halt_hit = instr_valid && (instr == HALT_A || instr == HALT_B);
  // drain counter runs 0..DRAIN_CYCLES so the first read lands DRAIN_CYCLES+1 cycles after halt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      cnt        <= '0;
      addr       <= '0;
      halted     <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_addr  <= '0;
      word_count <= '0;
      done       <= 1'b0;
    end else begin
      case (state)
        RUN: if (halt_hit) begin
          state  <= DRAIN;
          halted <= 1'b1;
          cnt    <= '0;
        end
        DRAIN: if (cnt == 8'(DRAIN_CYCLES)) begin
          state     <= READ;
          addr      <= '0;
          mem_addr  <= '0;
          mem_rd_en <= 1'b1;
        end else cnt <= cnt + 8'd1;
        READ: begin
          mem_rd_en <= 1'b0;
          state     <= CHECK;
        end
        CHECK: if (mem_rdata != '0) begin
          dump_data  <= mem_rdata;
          dump_addr  <= addr[ADDR_W-1:0];
          dump_valid <= 1'b1;
          state      <= EMIT;
        end else if (last) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          addr      <= addr_nx;
          mem_addr  <= addr_nx[ADDR_W-1:0];
          mem_rd_en <= 1'b1;
          state     <= READ;
        end
        EMIT: if (dump_ready) begin
          dump_valid <= 1'b0;
          word_count <= word_count + (ADDR_W+1)'(1);
          if (last) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            addr      <= addr_nx;
            mem_addr  <= addr_nx[ADDR_W-1:0];
            mem_rd_en <= 1'b1;
            state     <= READ;
          end
        end
        DONE: state <= DONE;
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_halt_dump_unit.sv
// tb_halt_dump_unit: scoreboard bench for halt_dump_unit with a 16-word memory model
module tb_halt_dump_unit;
  localparam int AW = 4;
  localparam int DW = 16;
  localparam logic [15:0] HA = 16'hE000;
  localparam logic [15:0] HB = 16'hE7FF;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [15:0] instr = '0;
  logic instr_valid = 1'b0;
  logic halted, mem_rd_en, dump_valid, done;
  logic [AW-1:0] mem_addr, dump_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] dump_data;
  logic dump_ready = 1'b1;
  logic [AW:0] word_count;
  logic [DW-1:0] mem [16];
  logic [31:0] sb [$];
  int checks = 0, errors = 0, cyc = 0, t_halt = 0, valid_cnt = 0, v0;

  halt_dump_unit #(.ADDR_W(AW), .DATA_W(DW), .DRAIN_CYCLES(10), .HALT_A(HA), .HALT_B(HB)) dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .halted(halted), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_addr(dump_addr), .word_count(word_count), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // accepted beats are compared against the scoreboard in order
  always @(negedge clk) begin
    if (reset && dump_valid) begin
      valid_cnt <= valid_cnt + 1;
      if (dump_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          logic [31:0] e;
          e = sb.pop_front();
          chk("beat_addr", 32'(dump_addr), {16'd0, e[31:16]});
          chk("beat_data", 32'(dump_data), {16'd0, e[15:0]});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, "_valid"}, 32'(dump_valid), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_data"}, 32'(dump_data), 0);
    chk({tag, "_addr"}, 32'(dump_addr), 0);
    chk({tag, "_count"}, 32'(word_count), 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    sb.delete();
    reset = 1'b1;
    step();
  endtask

  task automatic load(input logic [15:0] v3, input logic [15:0] v15);
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[3] = v3;
    mem[15] = v15;
    for (int i = 0; i < 16; i++) if (mem[i] != '0) sb.push_back({16'(i), mem[i]});
  endtask

  task automatic halt(input logic [15:0] code, input bit dup);
    instr = code;
    instr_valid = 1'b1;
    step();
    t_halt = cyc;
    instr_valid = 1'b0;
    chk("halted_rise", 32'(halted), 1);
    for (int k = 1; k <= 40; k++) begin
      instr_valid = dup && k == 3;
      instr = HA;
      step();
      instr_valid = 1'b0;
      if (mem_rd_en) break;
    end
    chk("rd_latency", cyc - t_halt, 11);
  endtask

  task automatic wait_done(input int exp_t, input int n);
    for (int k = 0; k < 200 && !done; k++) step();
    chk("done_time", cyc - t_halt, exp_t);
    chk("halted_done", 32'(halted), 1);
    chk("word_count", 32'(word_count), n);
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 60 && !dump_valid; k++) step();
    chk("valid_seen", 32'(dump_valid), 1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    for (int i = 0; i < 3; i++) begin
      instr = 16'($urandom);
      instr_valid = 1'($urandom_range(0, 1));
      step();
      chk_zero("rst");
    end
    instr = 16'h0123;
    instr_valid = 1'b0;
    reset = 1'b1;
    step();
    step();
    chk_zero("idle");
    instr = HB;
    step();
    step();
    chk("invalid_halt", 32'(halted), 0);
    // basic dump with a second halt issued during drain
    load(16'h1234, 16'hBEEF);
    dump_ready = 1'b1;
    halt(HA, 1'b1);
    wait_done(45, 2);
    // backpressure on the first beat, halt via encoding B
    do_reset();
    load(16'h1234, 16'hBEEF);
    dump_ready = 1'b0;
    halt(HB, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(dump_valid), 1);
      chk("stall_data", 32'(dump_data), 32'h1234);
      chk("stall_addr", 32'(dump_addr), 3);
      chk("stall_rd_en", 32'(mem_rd_en), 0);
      chk("stall_count", 32'(word_count), 0);
      step();
    end
    dump_ready = 1'b1;
    step();
    chk("accept_count", 32'(word_count), 1);
    chk("accept_valid", 32'(dump_valid), 0);
    wait_done(50, 2);
    // all-zero memory
    do_reset();
    load(16'h0000, 16'h0000);
    v0 = valid_cnt;
    halt(HA, 1'b0);
    wait_done(43, 0);
    chk("zero_no_valid", valid_cnt - v0, 0);
    // async reset in the middle of a beat, then full rescan
    do_reset();
    load(16'h1234, 16'hBEEF);
    dump_ready = 1'b0;
    halt(HA, 1'b0);
    wait_valid();
    #2 reset = 1'b0;
    #1 chk_zero("async_rst");
    sb.delete();
    step();
    reset = 1'b1;
    step();
    chk_zero("post_rst");
    load(16'h1234, 16'hBEEF);
    dump_ready = 1'b1;
    halt(HA, 1'b0);
    wait_done(45, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
